// File: rtl/int_epc_controller.sv
// Interrupt entry/return sequencer: latches IRQ edges, redirects fetch to a vector at a safe point,
// saves the ID-stage PC to EPC and redirects back to it on ERET.
module int_epc_controller #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0008,
    parameter logic [1:0]  SEQUENCE   = 2'b00
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_wdata,
    input  logic               i_eret,
    input  logic [31:0]        i_ID_PC,
    input  logic               i_IF_ID_Stall,
    input  logic [1:0]         i_branch_Or_Jump,
    output logic               o_EPC_Selected,
    output logic [31:0]        o_PC_Int_Target,
    output logic               o_Int_IF_ID_Flush,
    output logic               o_Int_ID_EX_Flush,
    output logic [NUM_IRQ-1:0] o_int_ack,
    output logic [31:0]        o_EPC_out,
    output logic               o_in_service,
    output logic [NUM_IRQ-1:0] o_int_pending
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTER   = 2'd1,
        S_SERVICE = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_ack;
    logic               r_sel;
    logic [31:0]        r_target;
    logic [31:0]        r_epc;
    logic               r_in_service;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_cand;
    logic [IDX_W-1:0]   w_idx;
    logic               w_take;
    logic [31:0]        w_vec;
    logic [NUM_IRQ-1:0] w_onehot;

    assign w_edge = i_irq & ~r_irq_q;
    assign w_cand = r_pending & r_mask;

    // Lowest-index enabled pending line wins.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_take   = (r_state == S_IDLE) && (|w_cand) && !i_IF_ID_Stall
                      && (i_branch_Or_Jump == SEQUENCE);
    assign w_vec    = VEC_BASE + (32'(w_idx) * VEC_STRIDE);
    assign w_onehot = NUM_IRQ'(1) << w_idx;

    // Redirect outputs are loaded on the state transition so they depend on state alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_ack        <= '0;
            r_sel        <= 1'b0;
            r_target     <= '0;
            r_epc        <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_irq_q   <= i_irq;
            r_pending <= (r_pending & ~r_ack) | w_edge;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
            r_sel    <= 1'b0;
            r_target <= '0;
            r_ack    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state  <= S_ENTER;
                        r_sel    <= 1'b1;
                        r_target <= w_vec;
                        r_ack    <= w_onehot;
                    end
                end
                S_ENTER: begin
                    r_epc        <= i_ID_PC;
                    r_in_service <= 1'b1;
                    r_state      <= S_SERVICE;
                end
                S_SERVICE: begin
                    if (i_eret && !i_IF_ID_Stall) begin
                        r_state      <= S_RETURN;
                        r_sel        <= 1'b1;
                        r_target     <= r_epc;
                        r_in_service <= 1'b0;
                    end
                end
                S_RETURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_EPC_Selected    = r_sel;
    assign o_PC_Int_Target   = r_target;
    assign o_Int_IF_ID_Flush = r_sel;
    assign o_Int_ID_EX_Flush = r_sel;
    assign o_int_ack         = r_ack;
    assign o_EPC_out         = r_epc;
    assign o_in_service      = r_in_service;
    assign o_int_pending     = r_pending;

endmodule

// File: tb/tb_int_epc_controller.sv
// Self-checking bench for int_epc_controller: redirects are scoreboarded with their expected cycle.
module tb_int_epc_controller;

    typedef struct {
        int          cyc;
        logic [31:0] tgt;
        logic [3:0]  ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        eret;
    logic [31:0] id_pc;
    logic        stall;
    logic [1:0]  boj;
    logic        epc_sel;
    logic [31:0] pc_tgt;
    logic        flush_ifid;
    logic        flush_idex;
    logic [3:0]  int_ack;
    logic [31:0] epc_out;
    logic        in_service;
    logic [3:0]  int_pending;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   p;
    exp_t sb_q[$];

    int_epc_controller dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_irq            (irq),
        .i_mask_we        (mask_we),
        .i_mask_wdata     (mask_wdata),
        .i_eret           (eret),
        .i_ID_PC          (id_pc),
        .i_IF_ID_Stall    (stall),
        .i_branch_Or_Jump (boj),
        .o_EPC_Selected   (epc_sel),
        .o_PC_Int_Target  (pc_tgt),
        .o_Int_IF_ID_Flush(flush_ifid),
        .o_Int_ID_EX_Flush(flush_idex),
        .o_int_ack        (int_ack),
        .o_EPC_out        (epc_out),
        .o_in_service     (in_service),
        .o_int_pending    (int_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [31:0] t, input logic [3:0] a);
        exp_t e;
        e.cyc = c;
        e.tgt = t;
        e.ack = a;
        sb_q.push_back(e);
    endtask

    // Every redirect cycle must match the next scoreboard entry exactly.
    always @(negedge clk) begin
        if (epc_sel === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_redirect", 32'(pc_tgt), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("redir_cycle", 32'(cyc), 32'(e.cyc));
                check_eq("redir_target", pc_tgt, e.tgt);
                check_eq("redir_ack", 32'(int_ack), 32'(e.ack));
                check_eq("redir_flush", 32'({flush_ifid, flush_idex}), 32'h3);
            end
        end
    end

    initial begin
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; eret = 1'b0;
        id_pc = '0; stall = 1'b0; boj = 2'b00;
        step(2);
        check_eq("rst_sel", 32'(epc_sel), 32'h0);
        check_eq("rst_target", pc_tgt, 32'h0);
        check_eq("rst_ack", 32'(int_ack), 32'h0);
        check_eq("rst_epc", epc_out, 32'h0);
        check_eq("rst_in_service", 32'(in_service), 32'h0);
        check_eq("rst_pending", 32'(int_pending), 32'h0);
        reset = 1'b0;

        // Single irq[2] entry and return
        mask_we = 1'b1; mask_wdata = 4'b1111;
        step(1);
        mask_we = 1'b0; irq = 4'b0100; id_pc = 32'h40; p = cyc;
        push(p + 2, 32'h14, 4'b0100);
        step(1);
        irq = '0;
        step(2);
        check_eq("t1_epc", epc_out, 32'h40);
        check_eq("t1_in_service", 32'(in_service), 32'h1);
        check_eq("t1_pending_cleared", 32'(int_pending), 32'h0);
        eret = 1'b1;
        push(cyc + 1, 32'h40, 4'b0000);
        step(1);
        eret = 1'b0;
        step(1);
        check_eq("t1_idle", 32'(in_service), 32'h0);

        // Simultaneous irq[1] and irq[3]: priority, then back-to-back entry after return
        id_pc = 32'h100; irq = 4'b1010; p = cyc;
        push(p + 2, 32'h0C, 4'b0010);
        step(1);
        irq = '0;
        step(2);
        check_eq("t2_pending3", 32'(int_pending), 32'h8);
        check_eq("t2_epc", epc_out, 32'h100);
        eret = 1'b1; p = cyc;
        push(p + 1, 32'h100, 4'b0000);
        push(p + 3, 32'h1C, 4'b1000);
        step(1);
        eret = 1'b0; id_pc = 32'h200;
        step(3);
        check_eq("t2_epc2", epc_out, 32'h200);
        check_eq("t2_pending_empty", 32'(int_pending), 32'h0);
        eret = 1'b1;
        push(cyc + 1, 32'h200, 4'b0000);
        step(1);
        eret = 1'b0;
        step(1);

        // Stall and non-sequential control flow hold off the entry
        id_pc = 32'h300; stall = 1'b1; irq = 4'b0001; p = cyc;
        step(1);
        irq = '0;
        step(3);
        stall = 1'b0; boj = 2'b01;
        step(2);
        boj = 2'b00;
        push(p + 7, 32'h04, 4'b0001);
        step(2);
        check_eq("t3_in_service", 32'(in_service), 32'h1);
        // ERET held off while stalled
        eret = 1'b1; stall = 1'b1;
        step(2);
        check_eq("t5_eret_held", 32'(in_service), 32'h1);
        stall = 1'b0;
        push(cyc + 1, 32'h300, 4'b0000);
        step(1);
        eret = 1'b0;
        step(1);

        // Masked line stays pending until the mask opens
        mask_we = 1'b1; mask_wdata = 4'b0000;
        step(1);
        mask_we = 1'b0; irq = 4'b0001;
        step(1);
        irq = '0;
        step(2);
        check_eq("t4_pending_masked", 32'(int_pending), 32'h1);
        check_eq("t4_no_entry", 32'(in_service), 32'h0);
        id_pc = 32'h400; mask_we = 1'b1; mask_wdata = 4'b0001;
        push(cyc + 2, 32'h04, 4'b0001);
        step(1);
        mask_we = 1'b0;
        step(2);
        check_eq("t4_epc", epc_out, 32'h400);
        eret = 1'b1;
        push(cyc + 1, 32'h400, 4'b0000);
        step(1);
        eret = 1'b0;
        step(1);

        // ERET in IDLE is ignored
        eret = 1'b1;
        step(2);
        check_eq("t5_idle_eret_sel", 32'(epc_sel), 32'h0);
        check_eq("t5_idle_eret_svc", 32'(in_service), 32'h0);
        eret = 1'b0;
        step(1);

        // Reset during ENTER
        mask_we = 1'b1; mask_wdata = 4'b1111;
        step(1);
        mask_we = 1'b0; irq = 4'b1001; p = cyc;
        push(p + 2, 32'h04, 4'b0001);
        step(1);
        irq = '0;
        step(1);
        reset = 1'b1;
        step(1);
        check_eq("t6_sel", 32'(epc_sel), 32'h0);
        check_eq("t6_pending", 32'(int_pending), 32'h0);
        check_eq("t6_epc", epc_out, 32'h0);
        check_eq("t6_in_service", 32'(in_service), 32'h0);
        reset = 1'b0;
        step(3);
        check_eq("t6_post_pending", 32'(int_pending), 32'h0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
